lfsr_axi_poller: RTL and testbench

AXI4-Lite read master sitting directly upstream of the `LFSR_v1_0` slave. It replaces hand-driven bus reads: on a `start` pulse it issues a programmed number of single-beat reads at incrementing register addresses and captures each `rdata` word. Captured words go into a small FIFO and leave on a valid/ready stream for downstream consumers such as a DMA packer or a UART dumper. Read channels only; the master has no write channels, and the slave's write inputs are tied off at the top level.

---
 rtl/lfsr_axi_poller.sv | 135 +++++++++++++
 tb/tb_lfsr_axi_poller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_axi_poller.sv
// AXI4-Lite read master: on start, issues num_reads single-beat reads at incrementing
// addresses and streams the returned words out through a small FIFO.
module lfsr_axi_poller #(
  parameter int C_M00_AXI_ADDR_WIDTH = 4,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int ADDR_INC             = 4,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            start,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]                      num_reads,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_err,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready
);
  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      remain_q, remain_d;
  logic            arvalid_q, arvalid_d;
  logic            rd_err_q, rd_err_d;

  logic [FIFO_DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic fifo_full, pop, push;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so the beat can be accepted even when full.
  assign m00_axi_rready = (state_q == S_DATA) && (!fifo_full || pop);
  assign push      = m00_axi_rvalid && m00_axi_rready;

  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_arprot  = 3'b000;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_FIN);
  assign rd_err          = rd_err_q;
  assign out_data        = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    arvalid_d = arvalid_q;
    rd_err_d  = rd_err_q;
    case (state_q)
      S_IDLE: if (start) begin
        rd_err_d = 1'b0;
        if (num_reads != 8'd0) begin
          addr_d    = base_addr;
          remain_d  = num_reads;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end else begin
          state_d = S_FIN;
        end
      end
      S_ADDR: if (m00_axi_arready) begin
        arvalid_d = 1'b0;
        state_d   = S_DATA;
      end
      S_DATA: if (push) begin
        addr_d   = addr_q + AW'(ADDR_INC);
        remain_d = remain_q - 8'd1;
        rd_err_d = rd_err_q | (m00_axi_rresp != 2'b00);
        if (remain_q == 8'd1) begin
          state_d = S_FIN;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      arvalid_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      arvalid_q <= arvalid_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= m00_axi_rdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_axi_poller.sv
// Directed bench for lfsr_axi_poller with a behavioural 4-register AXI-Lite read slave.
module tb_lfsr_axi_poller;
  localparam logic [31:0] W0 = 32'hDEAD_0000;
  localparam logic [31:0] W1 = 32'hBEEF_0004;
  localparam logic [31:0] W2 = 32'hCAFE_0008;
  localparam logic [31:0] W3 = 32'hF00D_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [7:0]  num_reads = '0;
  logic        busy, done, rd_err;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, rready, out_valid;
  logic        arready, rvalid;
  logic [31:0] rdata, out_data;
  logic [1:0]  rresp;
  logic        out_ready = 1'b1;
  logic        err_en = 1'b0;
  logic [3:0]  err_addr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  ar_q[$];
  logic [31:0] pop_q[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  lfsr_axi_poller dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .start(start), .base_addr(base_addr), .num_reads(num_reads),
    .busy(busy), .done(done), .rd_err(rd_err),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [31:0] slave_reg(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return W2;
      default: return W3;
    endcase
  endfunction

  // Slave: arready one cycle after arvalid, rvalid the cycle after the address handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      arready <= arvalid && !arready && !rvalid;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= slave_reg(araddr);
        rresp  <= (err_en && araddr == err_addr) ? 2'b10 : 2'b00;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (arvalid && arready) ar_q.push_back(araddr);
    if (out_valid && out_ready) pop_q.push_back(out_data);
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Leaves the bench #1 after the accepting edge, i.e. inside cycle 1.
  task automatic start_seq(input logic [3:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_reads = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_tests++; if ({busy, done, rd_err, arvalid, rready, out_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, rd_err, arvalid, rready, out_valid}); end
    n_tests++; if (araddr !== 4'h0 || arprot !== 3'b000) begin
      n_fail++; $display("FAIL reset_addr got %h/%b want 0/000", araddr, arprot); end
    n_tests++; if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_seq4;
    int a0, p0, d0, first;
    logic [3:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{4'h0, 4'h4, 4'h8, 4'hC};
    ed = '{W0, W1, W2, W3};
    out_ready = 1'b1;
    a0 = ar_q.size(); p0 = pop_q.size(); d0 = done_cnt; first = 0;
    start_seq(4'h0, 8'd4);
    n_tests++; if (arvalid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL seq4_cycle1 arvalid=%b busy=%b want 1 1", arvalid, busy); end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done && first == 0) first = k;
    end
    n_tests++; if (first != 13) begin
      n_fail++; $display("FAIL seq4_done_cycle got %0d want 13", first); end
    n_tests++; if (ar_q.size() - a0 != 4 || pop_q.size() - p0 != 4) begin
      n_fail++; $display("FAIL seq4_counts ar=%0d pop=%0d want 4 4", ar_q.size() - a0, pop_q.size() - p0); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ar_q[a0+i] !== ea[i]) begin
        n_fail++; $display("FAIL seq4_araddr[%0d] got %h want %h", i, ar_q[a0+i], ea[i]); end
      n_tests++; if (pop_q[p0+i] !== ed[i]) begin
        n_fail++; $display("FAIL seq4_data[%0d] got %h want %h", i, pop_q[p0+i], ed[i]); end
    end
    n_tests++; if (done_cnt - d0 != 1 || rd_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL seq4_end done=%0d rd_err=%b busy=%b want 1 0 0", done_cnt - d0, rd_err, busy); end
  endtask

  task automatic test_wrap;
    int a0, p0, cyc;
    a0 = ar_q.size(); p0 = pop_q.size();
    start_seq(4'hC, 8'd2);
    wait_done(40, cyc);
    n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL wrap_timeout got none want done"); end
    repeat (3) @(negedge clk);
    n_tests++; if (ar_q.size() - a0 != 2 || ar_q[a0] !== 4'hC || ar_q[a0+1] !== 4'h0) begin
      n_fail++; $display("FAIL wrap_araddr got %h,%h want c,0", ar_q[a0], ar_q[a0+1]); end
    n_tests++; if (pop_q[p0] !== W3 || pop_q[p0+1] !== W0) begin
      n_fail++; $display("FAIL wrap_data got %h,%h want %h,%h", pop_q[p0], pop_q[p0+1], W3, W0); end
  endtask

  task automatic test_stall;
    int a0, p0, d0, cyc;
    logic [31:0] ed[6];
    ed = '{W0, W1, W2, W3, W0, W1};
    a0 = ar_q.size(); p0 = pop_q.size(); d0 = done_cnt;
    out_ready = 1'b0;
    start_seq(4'h0, 8'd6);
    repeat (30) @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || rready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_state valid=%b rready=%b busy=%b want 1 0 1", out_valid, rready, busy); end
    n_tests++; if (ar_q.size() - a0 != 5 || done_cnt != d0) begin
      n_fail++; $display("FAIL stall_progress ar=%0d done=%0d want 5 0", ar_q.size() - a0, done_cnt - d0); end
    @(posedge clk); #1; out_ready = 1'b1; #1;
    n_tests++; if (rready !== 1'b1) begin
      n_fail++; $display("FAIL stall_pop_rready got %b want 1", rready); end
    wait_done(60, cyc);
    n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL stall_timeout got none want done"); end
    repeat (8) @(negedge clk);
    n_tests++; if (pop_q.size() - p0 != 6 || done_cnt - d0 != 1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain pops=%0d done=%0d valid=%b want 6 1 0", pop_q.size() - p0, done_cnt - d0, out_valid); end
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (pop_q[p0+i] !== ed[i]) begin
        n_fail++; $display("FAIL stall_data[%0d] got %h want %h", i, pop_q[p0+i], ed[i]); end
    end
  endtask

  task automatic test_err;
    int cyc;
    err_en = 1'b1; err_addr = 4'h4;
    start_seq(4'h0, 8'd3);
    repeat (4) @(negedge clk);
    n_tests++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_early got %b want 0", rd_err); end
    wait_done(40, cyc);
    n_tests++; if (cyc < 0 || rd_err !== 1'b1) begin
      n_fail++; $display("FAIL err_at_done cyc=%0d rd_err=%b want done 1", cyc, rd_err); end
    repeat (3) @(negedge clk);
    n_tests++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", rd_err); end
    err_en = 1'b0;
    start_seq(4'h0, 8'd1);
    n_tests++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", rd_err); end
    wait_done(20, cyc);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero;
    int a0, d0, first;
    logic saw;
    a0 = ar_q.size(); d0 = done_cnt; first = 0; saw = 1'b0;
    start_seq(4'h8, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (arvalid) saw = 1'b1;
      if (done && first == 0) first = k;
    end
    // done shows in the cycle right after the accepting edge.
    n_tests++; if (first != 1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL zero_done cycle=%0d pulses=%0d want 1 1", first, done_cnt - d0); end
    n_tests++; if (saw !== 1'b0 || ar_q.size() != a0) begin
      n_fail++; $display("FAIL zero_no_bus arvalid_seen=%b ar=%0d want 0 0", saw, ar_q.size() - a0); end
  endtask

  task automatic test_busy_start;
    int a0, p0, d0, cyc;
    a0 = ar_q.size(); p0 = pop_q.size(); d0 = done_cnt;
    start_seq(4'h0, 8'd2);
    repeat (2) @(posedge clk); #1;
    start = 1'b1; base_addr = 4'h8; num_reads = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    wait_done(40, cyc);
    repeat (6) @(negedge clk);
    n_tests++; if (ar_q.size() - a0 != 2 || ar_q[a0] !== 4'h0 || ar_q[a0+1] !== 4'h4) begin
      n_fail++; $display("FAIL busystart_araddr n=%0d got %h,%h want 2 0,4", ar_q.size() - a0, ar_q[a0], ar_q[a0+1]); end
    n_tests++; if (pop_q.size() - p0 != 2 || pop_q[p0] !== W0 || pop_q[p0+1] !== W1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL busystart_data n=%0d done=%0d want 2 1", pop_q.size() - p0, done_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busystart_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    start_seq(4'h0, 8'd4);
    repeat (3) @(posedge clk); #1;
    n_tests++; if (arvalid !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre arvalid=%b valid=%b want 1 1", arvalid, out_valid); end
    rst_n = 1'b0; #1;
    n_tests++; if ({busy, done, rd_err, arvalid, rready, out_valid} !== 6'b0 || araddr !== 4'h0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs ctrl=%b addr=%h data=%h want 0", {busy, done, rd_err, arvalid, rready, out_valid}, araddr, out_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after valid=%b busy=%b arvalid=%b want 0 0 0", out_valid, busy, arvalid); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_seq4();
    test_wrap();
    test_stall();
    test_err();
    test_zero();
    test_busy_start();
    test_reset_mid();
    test_seq4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
